instr_fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit processor, directly upstream of `OpcodeDecoder`. Holds a program counter and a loadable, synchronous-read instruction memory, and streams 16-bit instruction words plus their PCs to the decoder over a valid/ready handshake. Supports redirect (branch/jump) with flush, backpressure through a 2-entry output buffer, and halt on a sentinel word. Instruction fields (opcode[15:13], rA[12:10], rB[9:7], rC/imm[6:0]) pass through untouched.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Decoder-side handshake between the fetch stage and OpcodeDecoder.
// The master drives the instruction stream; the slave answers with out_ready.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, loadable synchronous-read program memory and a
// 2-entry output buffer feeding the decoder, with redirect/flush and halt-on-sentinel.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]       HALT_WORD = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [15:0]        load_data,
    input  logic               run,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    instr_fetch_unit_if.master dec,
    output logic               halted
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              inflight_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic [15:0]       rd_data_reg;
    logic [1:0]        count_reg, count_next;
    logic [15:0]       buf_instr_reg [2];
    logic [15:0]       buf_instr_next [2];
    logic [ADDR_W-1:0] buf_pc_reg [2];
    logic [ADDR_W-1:0] buf_pc_next [2];
    logic              valid_reg;
    logic              halted_reg;

    logic [15:0]       mem [DEPTH];

    logic              fetching;
    logic              loadable;
    logic              start;
    logic              pop;
    logic              do_redirect;
    logic              ret_halt;
    logic              push;
    logic              issue;
    logic [1:0]        count_after_pop;

    assign fetching        = (state_reg == FETCH);
    assign loadable        = (state_reg == IDLE) || (state_reg == HALTED);
    assign start           = run && loadable;
    assign pop             = valid_reg && dec.out_ready;
    assign do_redirect     = fetching && redirect_valid;
    assign ret_halt        = fetching && inflight_reg && (rd_data_reg == HALT_WORD);
    assign push            = fetching && inflight_reg && !ret_halt && !do_redirect;
    assign count_after_pop = count_reg - {1'b0, pop};

    // Issue only if the word will have a slot once this cycle's pop and return
    // have settled; counting the pop keeps a full-rate stream free of bubbles.
    assign issue = fetching && !do_redirect && !ret_halt &&
                   ((count_after_pop + {1'b0, inflight_reg}) < 2'd2);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        for (int i = 0; i < 2; i++) begin
            buf_instr_next[i] = buf_instr_reg[i];
            buf_pc_next[i]    = buf_pc_reg[i];
        end

        case (state_reg)
            IDLE, HALTED: begin
                if (run) begin
                    state_next = FETCH;
                    pc_next    = RESET_PC;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end else if (ret_halt) begin
                    state_next = HALTED;
                end else if (issue) begin
                    pc_next = pc_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A transfer coinciding with a redirect has already been seen by the
        // decoder, so clearing the whole buffer is all that is left to do.
        if (start || do_redirect) begin
            count_next = '0;
        end else begin
            if (pop) begin
                buf_instr_next[0] = buf_instr_reg[1];
                buf_pc_next[0]    = buf_pc_reg[1];
                count_next        = count_after_pop;
            end
            if (push) begin
                buf_instr_next[count_after_pop[0]] = rd_data_reg;
                buf_pc_next[count_after_pop[0]]    = inflight_pc_reg;
                count_next                         = count_after_pop + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            count_reg       <= '0;
            valid_reg       <= 1'b0;
            halted_reg      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_instr_reg[i] <= '0;
                buf_pc_reg[i]    <= '0;
            end
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
            end
            count_reg  <= count_next;
            valid_reg  <= (count_next != 2'd0);
            halted_reg <= (state_next == HALTED) && (count_next == 2'd0);
            for (int i = 0; i < 2; i++) begin
                buf_instr_reg[i] <= buf_instr_next[i];
                buf_pc_reg[i]    <= buf_pc_next[i];
            end
        end
    end

    // Program memory is deliberately outside the reset so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (load_en && loadable) begin
            mem[load_addr] <= load_data;
        end
        if (issue) begin
            rd_data_reg <= mem[pc_reg];
        end
    end

    assign dec.out_valid = valid_reg;
    assign dec.out_instr = buf_instr_reg[0];
    assign dec.out_pc    = buf_pc_reg[0];
    assign halted        = halted_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: startup latency, streaming, backpressure,
// redirect, halt, reset mid-run, ignored controls and PC wrap (second instance).
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    localparam int ADDR_W = 8;
    localparam logic [15:0] PROG [4] = '{16'h0102, 16'h2081, 16'h4081, 16'hFFFF};

    logic              clk = 1'b0;
    logic              rst;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic              run_a;
    logic              run_b;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted_a;
    logic              halted_b;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] rx_pc [$];
    logic [15:0]       rx_instr [$];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus_a ();
    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus_b ();

    instr_fetch_unit #(
        .ADDR_W(ADDR_W), .DEPTH(256), .RESET_PC(8'd0), .HALT_WORD(16'hFFFF)
    ) dut_a (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .run(run_a),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec(bus_a),
        .halted(halted_a)
    );

    instr_fetch_unit #(
        .ADDR_W(ADDR_W), .DEPTH(256), .RESET_PC(8'd254), .HALT_WORD(16'hFFFF)
    ) dut_b (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .run(run_b),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec(bus_b),
        .halted(halted_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] addr, input logic [15:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_program;
        for (int i = 0; i < 4; i++) load_word(ADDR_W'(i), PROG[i]);
    endtask

    task automatic pulse_run(input bit sel_b);
        if (sel_b) run_b = 1'b1; else run_a = 1'b1;
        tick();
        run_a = 1'b0;
        run_b = 1'b0;
    endtask

    // Records every transfer until the selected instance reports halted.
    task automatic collect(input bit sel_b, input int max_cycles, output bit done);
        done = 1'b0;
        rx_pc.delete();
        rx_instr.delete();
        for (int c = 0; c < max_cycles; c++) begin
            if (!sel_b && bus_a.out_valid && bus_a.out_ready) begin
                rx_pc.push_back(bus_a.out_pc);
                rx_instr.push_back(bus_a.out_instr);
                $display("xfer a pc=%0d instr=%04h", bus_a.out_pc, bus_a.out_instr);
            end
            if (sel_b && bus_b.out_valid && bus_b.out_ready) begin
                rx_pc.push_back(bus_b.out_pc);
                rx_instr.push_back(bus_b.out_instr);
                $display("xfer b pc=%0d instr=%04h", bus_b.out_pc, bus_b.out_instr);
            end
            if ((!sel_b && halted_a) || (sel_b && halted_b)) begin
                done = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        tick();
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_a.out_valid); end
        checks++; if (bus_a.out_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %04h want 0000", bus_a.out_instr); end
        checks++; if (bus_a.out_pc !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", bus_a.out_pc); end
        checks++; if (halted_a !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted_a); end
        $display("reset checked");
    endtask

    task automatic test_stream;
        bus_a.out_ready = 1'b1;
        load_program();
        pulse_run(1'b0);
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_e0: got %b want 0", bus_a.out_valid); end
        tick();
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_e1: got %b want 0", bus_a.out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("stream cycle %0d pc=%0d instr=%04h valid=%b", i, bus_a.out_pc, bus_a.out_instr, bus_a.out_valid);
            checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus_a.out_valid); end
            checks++; if (bus_a.out_pc !== ADDR_W'(i)) begin errors++; $display("FAIL stream_pc[%0d]: got %0d want %0d", i, bus_a.out_pc, i); end
            checks++; if (bus_a.out_instr !== PROG[i]) begin errors++; $display("FAIL stream_instr[%0d]: got %04h want %04h", i, bus_a.out_instr, PROG[i]); end
            checks++; if (halted_a !== 1'b0) begin errors++; $display("FAIL stream_halted[%0d]: got %b want 0", i, halted_a); end
        end
        tick();
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL stream_halt_valid: got %b want 0", bus_a.out_valid); end
        checks++; if (halted_a !== 1'b1) begin errors++; $display("FAIL stream_halted_end: got %b want 1", halted_a); end
    endtask

    task automatic test_backpressure;
        bit done;
        bus_a.out_ready = 1'b0;
        pulse_run(1'b0);
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            $display("stall cycle %0d pc=%0d instr=%04h valid=%b", c, bus_a.out_pc, bus_a.out_instr, bus_a.out_valid);
            checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus_a.out_valid); end
            checks++; if (bus_a.out_instr !== 16'h0102) begin errors++; $display("FAIL bp_instr[%0d]: got %04h want 0102", c, bus_a.out_instr); end
            checks++; if (bus_a.out_pc !== 8'd0) begin errors++; $display("FAIL bp_pc[%0d]: got %0d want 0", c, bus_a.out_pc); end
            if (c < 5) tick();
        end
        bus_a.out_ready = 1'b1;
        collect(1'b0, 40, done);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_timeout: halted got %b want 1", halted_a); end
        checks++; if (rx_pc.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", rx_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_pc.size()) begin
                checks++; if (rx_pc[i] !== ADDR_W'(i) || rx_instr[i] !== PROG[i]) begin
                    errors++; $display("FAIL bp_xfer[%0d]: got (%0d,%04h) want (%0d,%04h)", i, rx_pc[i], rx_instr[i], i, PROG[i]);
                end
            end
        end
    endtask

    task automatic test_redirect;
        load_word(8'd8, 16'h6082);
        load_word(8'd9, 16'hFFFF);
        bus_a.out_ready = 1'b1;
        pulse_run(1'b0);
        tick();
        tick();
        checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 8'd0) begin errors++; $display("FAIL redir_pre: got valid=%b pc=%0d want 1/0", bus_a.out_valid, bus_a.out_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 8'd8;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 8'd0;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL redir_r0_valid: got %b want 0 (pc=%0d)", bus_a.out_valid, bus_a.out_pc); end
        tick();
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL redir_r1_valid: got %b want 0 (pc=%0d)", bus_a.out_valid, bus_a.out_pc); end
        tick();
        $display("redirect head pc=%0d instr=%04h valid=%b", bus_a.out_pc, bus_a.out_instr, bus_a.out_valid);
        checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL redir_r2_valid: got %b want 1", bus_a.out_valid); end
        checks++; if (bus_a.out_pc !== 8'd8) begin errors++; $display("FAIL redir_r2_pc: got %0d want 8", bus_a.out_pc); end
        checks++; if (bus_a.out_instr !== 16'h6082) begin errors++; $display("FAIL redir_r2_instr: got %04h want 6082", bus_a.out_instr); end
        tick();
        checks++; if (bus_a.out_valid !== 1'b0 || halted_a !== 1'b1) begin errors++; $display("FAIL redir_halt: got valid=%b halted=%b want 0/1", bus_a.out_valid, halted_a); end
    endtask

    task automatic test_rst_midrun;
        bit done;
        bus_a.out_ready = 1'b0;
        pulse_run(1'b0);
        tick();
        tick();
        tick();
        checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", bus_a.out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus_a.out_valid); end
        checks++; if (bus_a.out_pc !== 8'd0 || bus_a.out_instr !== 16'h0000) begin errors++; $display("FAIL rst_outs: got pc=%0d instr=%04h want 0/0000", bus_a.out_pc, bus_a.out_instr); end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (bus_a.out_valid !== 1'b0 || halted_a !== 1'b0) begin errors++; $display("FAIL rst_idle: got valid=%b halted=%b want 0/0", bus_a.out_valid, halted_a); end
        bus_a.out_ready = 1'b1;
        pulse_run(1'b0);
        collect(1'b0, 40, done);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_rerun_timeout: halted got %b want 1", halted_a); end
        checks++; if (rx_pc.size() != 3) begin errors++; $display("FAIL rst_rerun_count: got %0d want 3", rx_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_pc.size()) begin
                checks++; if (rx_pc[i] !== ADDR_W'(i) || rx_instr[i] !== PROG[i]) begin
                    errors++; $display("FAIL rst_rerun_xfer[%0d]: got (%0d,%04h) want (%0d,%04h)", i, rx_pc[i], rx_instr[i], i, PROG[i]);
                end
            end
        end
    endtask

    task automatic test_ignored_controls;
        bit done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 8'd5;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 8'd0;
        tick();
        checks++; if (bus_a.out_valid !== 1'b0 || halted_a !== 1'b0) begin errors++; $display("FAIL idle_redirect: got valid=%b halted=%b want 0/0", bus_a.out_valid, halted_a); end
        bus_a.out_ready = 1'b0;
        pulse_run(1'b0);
        load_word(8'd2, 16'hDEAD);
        tick();
        bus_a.out_ready = 1'b1;
        collect(1'b0, 40, done);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_timeout: halted got %b want 1", halted_a); end
        checks++; if (rx_pc.size() != 3) begin errors++; $display("FAIL ign_count: got %0d want 3", rx_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_pc.size()) begin
                checks++; if (rx_pc[i] !== ADDR_W'(i) || rx_instr[i] !== PROG[i]) begin
                    errors++; $display("FAIL ign_xfer[%0d]: got (%0d,%04h) want (%0d,%04h)", i, rx_pc[i], rx_instr[i], i, PROG[i]);
                end
            end
        end
    endtask

    task automatic test_pc_wrap;
        bit done;
        logic [ADDR_W-1:0] exp_pc [3];
        logic [15:0]       exp_instr [3];
        exp_pc    = '{8'd254, 8'd255, 8'd0};
        exp_instr = '{16'h1111, 16'h2222, 16'h3333};
        load_word(8'd254, 16'h1111);
        load_word(8'd255, 16'h2222);
        load_word(8'd0,   16'h3333);
        load_word(8'd1,   16'hFFFF);
        bus_b.out_ready = 1'b1;
        pulse_run(1'b1);
        collect(1'b1, 40, done);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_timeout: halted got %b want 1", halted_b); end
        checks++; if (rx_pc.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d want 3", rx_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_pc.size()) begin
                checks++; if (rx_pc[i] !== exp_pc[i] || rx_instr[i] !== exp_instr[i]) begin
                    errors++; $display("FAIL wrap_xfer[%0d]: got (%0d,%04h) want (%0d,%04h)", i, rx_pc[i], rx_instr[i], exp_pc[i], exp_instr[i]);
                end
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        load_en         = 1'b0;
        load_addr       = '0;
        load_data       = '0;
        run_a           = 1'b0;
        run_b           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_rst_midrun();
        test_ignored_controls();
        test_pc_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
